apsk_mapper: RTL and testbench

APSK_MAPPER -- requirements
Module: apsk_mapper

---
 rtl/apsk_pkg.sv | 106 ++++++++++
 rtl/apsk_map_rom.sv | 23 ++
 rtl/apsk_mapper.sv | 167 ++++++++++++++++
 tb/tb_apsk_mapper.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apsk_pkg.sv
// Shared APSK definitions: mode encodings, bits per symbol, FSM states and
// first-quadrant constellation points (Q7.10). The demapper table uses the same points.
package apsk_pkg;

  localparam int unsigned PT_W    = 18;
  localparam int unsigned PT_FRAC = 10;
  localparam int unsigned MODE_W  = 3;
  localparam int unsigned ACC_W   = 13;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned BASE_W  = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_QPSK   = 3'd0,
    MODE_8PSK   = 3'd1,
    MODE_16APSK = 3'd2,
    MODE_32APSK = 3'd3,
    MODE_64APSK = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [PT_W-1:0] re;
    logic signed [PT_W-1:0] im;
  } point_t;

  function automatic logic [CNT_W-1:0] bits_per_mode(input logic [MODE_W-1:0] mode);
    case (mode_e'(mode))
      MODE_QPSK:   return CNT_W'(2);
      MODE_8PSK:   return CNT_W'(3);
      MODE_16APSK: return CNT_W'(4);
      MODE_32APSK: return CNT_W'(5);
      MODE_64APSK: return CNT_W'(6);
      default:     return CNT_W'(0);
    endcase
  endfunction

  function automatic logic mode_valid(input logic [MODE_W-1:0] mode);
    return bits_per_mode(mode) != '0;
  endfunction

  function automatic point_t pt(input int re, input int im);
    point_t p;
    p.re = PT_W'(re);
    p.im = PT_W'(im);
    return p;
  endfunction

  // Index bit0 negates re, bit1 negates im; upper bits select a first-quadrant point, inner ring first.
  function automatic point_t base_point(input logic [MODE_W-1:0] mode, input logic [BASE_W-1:0] base);
    point_t p;
    p = pt(0, 0);
    case (mode_e'(mode))
      MODE_QPSK: p = pt(724, 724);
      MODE_8PSK: p = base[0] ? pt(392, 946) : pt(946, 392);
      MODE_16APSK: begin
        case (base[1:0])
          2'd0:    p = pt(283, 283);
          2'd1:    p = pt(989, 265);
          2'd2:    p = pt(724, 724);
          default: p = pt(265, 989);
        endcase
      end
      MODE_32APSK: begin
        case (base[2:0])
          3'd0:    p = pt(212, 212);
          3'd1:    p = pt(628, 168);
          3'd2:    p = pt(460, 460);
          3'd3:    p = pt(168, 628);
          3'd4:    p = pt(1004, 200);
          3'd5:    p = pt(851, 569);
          3'd6:    p = pt(569, 851);
          default: p = pt(200, 1004);
        endcase
      end
      MODE_64APSK: begin
        case (base)
          4'd0:    p = pt(141, 141);
          4'd1:    p = pt(435, 116);
          4'd2:    p = pt(318, 318);
          4'd3:    p = pt(116, 435);
          4'd4:    p = pt(721, 114);
          4'd5:    p = pt(650, 331);
          4'd6:    p = pt(516, 516);
          4'd7:    p = pt(331, 650);
          4'd8:    p = pt(114, 721);
          4'd9:    p = pt(1018, 115);
          4'd10:   p = pt(967, 338);
          4'd11:   p = pt(867, 545);
          4'd12:   p = pt(724, 724);
          4'd13:   p = pt(545, 867);
          4'd14:   p = pt(338, 967);
          default: p = pt(115, 1018);
        endcase
      end
      default: p = pt(0, 0);
    endcase
    return p;
  endfunction

endpackage

// File: rtl/apsk_map_rom.sv
// Combinational constellation lookup: (mode, symbol index) -> Q7.10 point.
import apsk_pkg::*;

module apsk_map_rom (
  input  logic [MODE_W-1:0]      i_mode,
  input  logic [IDX_W-1:0]       i_index,
  output logic signed [PT_W-1:0] o_re,
  output logic signed [PT_W-1:0] o_im
);

  point_t w_base;
  logic signed [PT_W-1:0] w_re;
  logic signed [PT_W-1:0] w_im;

  always_comb begin
    w_base = base_point(i_mode, i_index[IDX_W-1:2]);
    w_re   = w_base.re;
    w_im   = w_base.im;
    o_re   = i_index[0] ? -w_re : w_re;
    o_im   = i_index[1] ? -w_im : w_im;
  end

endmodule

// File: rtl/apsk_mapper.sv
// Byte-stream to APSK symbol mapper (QPSK..64APSK) with valid/ready on both sides.
// Optional per-frame accepted-symbol counter o_sym_cnt under APSK_MAPPER_SYMCNT_EN.
import apsk_pkg::*;

module apsk_mapper #(
  parameter int unsigned WORDLENGTH = 18,
  parameter int unsigned FRACTION   = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [MODE_W-1:0]            Mode,
  input  logic [7:0]                   i_data,
  input  logic                         i_valid,
  input  logic                         i_last,
  output logic                         o_ready,
  output logic signed [WORDLENGTH-1:0] o_re,
  output logic signed [WORDLENGTH-1:0] o_im,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_last,
`ifdef APSK_MAPPER_SYMCNT_EN
  output logic                         o_err,
  output logic [15:0]                  o_sym_cnt
`else
  output logic                         o_err
`endif
);

  state_e                       r_state;
  logic [MODE_W-1:0]            r_mode;
  logic [ACC_W-1:0]             r_acc;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_ready;
  logic                         r_valid;
  logic                         r_last;
  logic                         r_err;
  logic signed [WORDLENGTH-1:0] r_re;
  logic signed [WORDLENGTH-1:0] r_im;

  state_e                       w_state_nx;
  logic [MODE_W-1:0]            w_mode;
  logic [MODE_W-1:0]            w_mode_nx;
  logic [MODE_W-1:0]            w_ready_mode;
  logic [CNT_W-1:0]             w_k;
  logic [CNT_W-1:0]             w_cnt;
  logic [CNT_W-1:0]             w_cnt_nx;
  logic [ACC_W-1:0]             w_acc;
  logic [ACC_W-1:0]             w_win;
  logic [IDX_W-1:0]             w_mask;
  logic [IDX_W-1:0]             w_idx;
  logic                         w_accept;
  logic                         w_flushing;
  logic                         w_out_hs;
  logic                         w_out_free;
  logic                         w_pad;
  logic                         w_load;
  logic                         w_final;
  logic signed [PT_W-1:0]       w_rom_re;
  logic signed [PT_W-1:0]       w_rom_im;
  logic signed [WORDLENGTH-1:0] w_re_s;
  logic signed [WORDLENGTH-1:0] w_im_s;

  // Accepted bytes and a symbol load may share a cycle, so the load sees the appended accumulator.
  always_comb begin
    w_mode     = (r_state == ST_IDLE) ? Mode : r_mode;
    w_k        = bits_per_mode(w_mode);
    w_accept   = i_valid && r_ready && mode_valid(w_mode);
    w_acc      = w_accept ? ACC_W'({r_acc, i_data}) : r_acc;
    w_cnt      = w_accept ? (r_cnt + CNT_W'(8)) : r_cnt;
    w_flushing = (r_state == ST_FLUSH) || (w_accept && i_last);
    w_out_hs   = r_valid && i_ready;
    w_out_free = !r_valid || i_ready;
    w_pad      = w_flushing && (w_cnt != '0) && (w_cnt < w_k);
    w_load     = w_out_free && (w_cnt != '0) && ((w_cnt >= w_k) || w_pad);
    w_mask     = IDX_W'((7'd1 << w_k) - 7'd1);
    w_win      = w_pad ? (w_acc << (w_k - w_cnt)) : (w_acc >> (w_cnt - w_k));
    w_idx      = IDX_W'(w_win) & w_mask;
    w_cnt_nx   = w_cnt;
    if (w_load) begin
      w_cnt_nx = w_pad ? '0 : (w_cnt - w_k);
    end
    w_final    = w_load && w_flushing && (w_cnt_nx == '0);

    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nx = i_last ? ST_FLUSH : ST_RUN;
      ST_RUN:   if (w_accept && i_last) w_state_nx = ST_FLUSH;
      ST_FLUSH: if (w_out_hs && r_last) w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase

    w_mode_nx    = ((r_state == ST_IDLE) && w_accept) ? Mode : r_mode;
    w_ready_mode = (w_state_nx == ST_IDLE) ? Mode : w_mode_nx;
  end

  apsk_map_rom u_rom (
    .i_mode  (w_mode),
    .i_index (w_idx),
    .o_re    (w_rom_re),
    .o_im    (w_rom_im)
  );

  // Rescale the Q7.10 table to the configured output format.
  if (FRACTION >= PT_FRAC) begin : g_scale_up
    assign w_re_s = WORDLENGTH'(w_rom_re) <<< (FRACTION - PT_FRAC);
    assign w_im_s = WORDLENGTH'(w_rom_im) <<< (FRACTION - PT_FRAC);
  end else begin : g_scale_down
    assign w_re_s = WORDLENGTH'(w_rom_re >>> (PT_FRAC - FRACTION));
    assign w_im_s = WORDLENGTH'(w_rom_im >>> (PT_FRAC - FRACTION));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_re    <= '0;
      r_im    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_mode  <= w_mode_nx;
      r_acc   <= w_acc;
      r_cnt   <= w_cnt_nx;
      r_ready <= (w_state_nx != ST_FLUSH) && mode_valid(w_ready_mode)
                 && (w_cnt_nx < bits_per_mode(w_ready_mode));
      r_err   <= (w_state_nx == ST_IDLE) && !mode_valid(Mode);
      if (w_load) begin
        r_valid <= 1'b1;
        r_re    <= w_re_s;
        r_im    <= w_im_s;
        r_last  <= w_final;
      end else if (i_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

`ifdef APSK_MAPPER_SYMCNT_EN
  logic [15:0] r_sym_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_sym_cnt <= '0;
    end else if (w_out_hs && (r_sym_cnt != 16'hFFFF)) begin
      r_sym_cnt <= r_sym_cnt + 16'd1;
    end
  end

  assign o_sym_cnt = r_sym_cnt;
`endif

  assign o_ready = r_ready;
  assign o_err   = r_err;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_re    = r_re;
  assign o_im    = r_im;

endmodule

// File: tb/tb_apsk_mapper.sv
// Directed self-checking bench for apsk_mapper (default build, 18-bit Q7.10 outputs).
module tb_apsk_mapper;

  logic              clk;
  logic              rst_n;
  logic [2:0]        Mode;
  logic [7:0]        i_data;
  logic              i_valid;
  logic              i_last;
  logic              o_ready;
  logic signed [17:0] o_re;
  logic signed [17:0] o_im;
  logic              o_valid;
  logic              i_ready;
  logic              o_last;
  logic              o_err;
`ifdef APSK_MAPPER_SYMCNT_EN
  logic [15:0]       o_sym_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int re;
    int im;
    bit last;
  } sym_t;

  sym_t q[$];

  apsk_mapper #(.WORDLENGTH(18), .FRACTION(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Mode      (Mode),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .i_last    (i_last),
    .o_ready   (o_ready),
    .o_re      (o_re),
    .o_im      (o_im),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_last    (o_last),
`ifdef APSK_MAPPER_SYMCNT_EN
    .o_err     (o_err),
    .o_sym_cnt (o_sym_cnt)
`else
    .o_err     (o_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Symbols that will be taken downstream at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      sym_t s;
      s.re   = int'(o_re);
      s.im   = int'(o_im);
      s.last = o_last;
      q.push_back(s);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int  n    = 0;
    bit  done = 0;
    i_data  = d;
    i_valid = 1'b1;
    i_last  = last;
    while (!done && n < 50) begin
      @(negedge clk);
      done = (o_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_byte 0x%02h: o_ready never seen within 50 cycles", d);
    end
  endtask

  task automatic wait_syms(input int n, input string tag);
    int cyc = 0;
    while (q.size() < n && cyc < 100) begin
      step(1);
      cyc++;
    end
    n_checks++;
    if (q.size() < n) begin
      n_fail++;
      $display("FAIL %s symbol count: got %0d, expected %0d", tag, q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Mode = 3'd0; i_data = '0; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    step(3);
    n_checks++;
    if ({o_valid, o_ready, o_last, o_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset flags: valid/ready/last/err=%b, expected 0000", {o_valid, o_ready, o_last, o_err});
    end
    n_checks++;
    if (o_re !== 18'sd0 || o_im !== 18'sd0) begin
      n_fail++;
      $display("FAIL reset data: re=%0d im=%0d, expected 0 0", o_re, o_im);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    n_checks++;
    if (o_ready !== 1'b1 || o_err !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post-reset idle: ready=%b err=%b valid=%b, expected 1 0 0", o_ready, o_err, o_valid);
    end
  endtask

  task automatic test_qpsk();
    int exp_re[4] = '{724, -724, 724, -724};
    int exp_im[4] = '{724, 724, -724, -724};
    q.delete();
    Mode = 3'd0; i_ready = 1'b1;
    send_byte(8'h1B, 1'b1);
    n_checks++;
    if (o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL qpsk latency: o_valid=%b one cycle after accept, expected 1", o_valid);
    end
    wait_syms(4, "qpsk");
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= q.size() || q[i].re !== exp_re[i] || q[i].im !== exp_im[i] || q[i].last !== (i == 3)) begin
        n_fail++;
        if (i < q.size())
          $display("FAIL qpsk sym%0d: (%0d,%0d,last=%0d), expected (%0d,%0d,last=%0d)",
                   i, q[i].re, q[i].im, q[i].last, exp_re[i], exp_im[i], i == 3);
        else
          $display("FAIL qpsk sym%0d: missing, expected (%0d,%0d)", i, exp_re[i], exp_im[i]);
      end
    end
    step(3);
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || q.size() != 4) begin
      n_fail++;
      $display("FAIL qpsk end: valid=%b ready=%b count=%0d, expected 0 1 4", o_valid, o_ready, q.size());
    end
  endtask

  task automatic test_64apsk_pad();
    int exp_re[2] = '{-115, 724};
    int exp_im[2] = '{-1018, 724};
    q.delete();
    Mode = 3'd4; i_ready = 1'b1;
    step(2);
    send_byte(8'hFF, 1'b1);
    wait_syms(2, "64apsk");
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (i >= q.size() || q[i].re !== exp_re[i] || q[i].im !== exp_im[i] || q[i].last !== (i == 1)) begin
        n_fail++;
        if (i < q.size())
          $display("FAIL 64apsk sym%0d: (%0d,%0d,last=%0d), expected (%0d,%0d,last=%0d)",
                   i, q[i].re, q[i].im, q[i].last, exp_re[i], exp_im[i], i == 1);
        else
          $display("FAIL 64apsk sym%0d: missing", i);
      end
    end
    step(3);
    n_checks++;
    if (q.size() != 2) begin
      n_fail++;
      $display("FAIL 64apsk extra symbols: count=%0d, expected 2", q.size());
    end
  endtask

  task automatic test_stall();
    int exp_re[8] = '{-724, 724, -724, 724, 724, -724, 724, -724};
    int exp_im[8] = '{-724, -724, 724, 724, 724, 724, -724, -724};
    q.delete();
    Mode = 3'd0; i_ready = 1'b0;
    step(2);
    send_byte(8'hE4, 1'b0);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_re !== -18'sd724 || o_im !== -18'sd724 || o_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall cycle%0d: valid=%b re=%0d im=%0d ready=%b, expected 1 -724 -724 0",
                 c, o_valid, o_re, o_im, o_ready);
      end
      step(1);
    end
    i_ready = 1'b1;
    send_byte(8'h1B, 1'b1);
    wait_syms(8, "stall");
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= q.size() || q[i].re !== exp_re[i] || q[i].im !== exp_im[i] || q[i].last !== (i == 7)) begin
        n_fail++;
        if (i < q.size())
          $display("FAIL stall sym%0d: (%0d,%0d,last=%0d), expected (%0d,%0d,last=%0d)",
                   i, q[i].re, q[i].im, q[i].last, exp_re[i], exp_im[i], i == 7);
        else
          $display("FAIL stall sym%0d: missing", i);
      end
    end
    step(3);
  endtask

  task automatic test_reserved_mode();
    int exp_re[3] = '{946, -946, 946};
    int exp_im[3] = '{392, 392, -392};
    q.delete();
    i_ready = 1'b1;
    Mode = 3'd5;
    step(2);
    n_checks++;
    if (o_err !== 1'b1 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reserved mode: err=%b ready=%b, expected 1 0", o_err, o_ready);
    end
    Mode = 3'd1;
    step(2);
    n_checks++;
    if (o_err !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mode recovery: err=%b ready=%b, expected 0 1", o_err, o_ready);
    end
    send_byte(8'h05, 1'b1);
    wait_syms(3, "8psk");
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= q.size() || q[i].re !== exp_re[i] || q[i].im !== exp_im[i] || q[i].last !== (i == 2)) begin
        n_fail++;
        if (i < q.size())
          $display("FAIL 8psk sym%0d: (%0d,%0d,last=%0d), expected (%0d,%0d,last=%0d)",
                   i, q[i].re, q[i].im, q[i].last, exp_re[i], exp_im[i], i == 2);
        else
          $display("FAIL 8psk sym%0d: missing", i);
      end
    end
    step(3);
  endtask

  task automatic test_reset_mid_frame();
    int exp_re[2] = '{-212, 200};
    int exp_im[2] = '{212, 1004};
    q.delete();
    Mode = 3'd3; i_ready = 1'b0;
    step(2);
    send_byte(8'hA5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_valid, o_ready, o_last, o_err} !== 4'b0000 || o_re !== 18'sd0 || o_im !== 18'sd0) begin
      n_fail++;
      $display("FAIL async reset: valid/ready/last/err=%b re=%0d im=%0d, expected 0000 0 0",
               {o_valid, o_ready, o_last, o_err}, o_re, o_im);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    i_ready = 1'b1;
    q.delete();
    step(4);
    n_checks++;
    if (o_valid !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL post-reset residue: valid=%b count=%0d, expected 0 0", o_valid, q.size());
    end
    send_byte(8'h0F, 1'b1);
    wait_syms(2, "32apsk");
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (i >= q.size() || q[i].re !== exp_re[i] || q[i].im !== exp_im[i] || q[i].last !== (i == 1)) begin
        n_fail++;
        if (i < q.size())
          $display("FAIL 32apsk sym%0d: (%0d,%0d,last=%0d), expected (%0d,%0d,last=%0d)",
                   i, q[i].re, q[i].im, q[i].last, exp_re[i], exp_im[i], i == 1);
        else
          $display("FAIL 32apsk sym%0d: missing", i);
      end
    end
    step(3);
  endtask

  task automatic test_mode_toggle();
    int exp_re[4] = '{-283, 283, -283, 989};
    int exp_im[4] = '{283, -283, -283, 265};
    q.delete();
    Mode = 3'd2; i_ready = 1'b1;
    step(2);
    send_byte(8'h12, 1'b0);
    Mode = 3'd4;
    send_byte(8'h34, 1'b1);
    wait_syms(4, "toggle");
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= q.size() || q[i].re !== exp_re[i] || q[i].im !== exp_im[i] || q[i].last !== (i == 3)) begin
        n_fail++;
        if (i < q.size())
          $display("FAIL toggle sym%0d: (%0d,%0d,last=%0d), expected (%0d,%0d,last=%0d)",
                   i, q[i].re, q[i].im, q[i].last, exp_re[i], exp_im[i], i == 3);
        else
          $display("FAIL toggle sym%0d: missing", i);
      end
    end
    step(3);
    n_checks++;
    if (q.size() != 4 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle end: count=%0d valid=%b, expected 4 0", q.size(), o_valid);
    end
    Mode = 3'd0;
  endtask

  initial begin
    test_reset();
    test_qpsk();
    test_64apsk_pad();
    test_stall();
    test_reserved_mode();
    test_reset_mid_frame();
    test_mode_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
